// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared opcode constants, 2-bit counter encodings and RAS
//                snapshot type for the fetch-stage branch predictors.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Sized for the largest supported stack (256 entries).
    localparam int SNAP_PTR_W = 8;

    typedef struct packed {
        logic [SNAP_PTR_W-1:0] ptr;
        logic [SNAP_PTR_W:0]   cnt;
    } ras_snap_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        case (ctr)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            default: return taken ? ST  : WT;
        endcase
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack with saturating occupancy and
//                pointer/count restore.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter  int RAS_DEPTH = 8,
    localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      push_data,
    input  logic             restore,
    input  logic [PTR_W-1:0] restore_ptr,
    input  logic [PTR_W:0]   restore_cnt,
    output logic [31:0]      top,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W:0]   cnt
);

    localparam logic [PTR_W:0] c_cnt_full = (PTR_W+1)'(RAS_DEPTH);

    logic [31:0]      stk_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_m1;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign ptr_m1 = ptr_q - PTR_W'(1);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (restore) begin
            ptr_d = restore_ptr;
            cnt_d = restore_cnt;
        end else if (push && pop) begin
            // Pop then push collapses to rewriting the current top in place.
            wr_en  = 1'b1;
            wr_idx = ptr_m1;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = (cnt_q == c_cnt_full) ? cnt_q : cnt_q + (PTR_W+1)'(1);
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) stk_q[wr_idx] <= push_data;
        end
    end

    assign top = stk_q[ptr_m1];
    assign ptr = ptr_q;
    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_predict_gshare_ras.sv
// ============================================================================
//  Module      : branch_predict_gshare_ras
//  Description : Fetch-stage predictor: RV32/RVC pre-decode, gshare PHT for
//                conditional branches, direct jumps and a RAS for returns.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_predict_gshare_ras
    import riscv_pkg::*;
#(
    parameter  int PHT_DEPTH  = 1024,
    parameter  int GHR_W      = 8,
    parameter  bit ENA_GSHARE = 1'b1,
    parameter  int RAS_DEPTH  = 8,
    parameter  bit ENA_RAS    = 1'b1,
    parameter  bit ENA_JUMP   = 1'b1,
    localparam int IDX_W      = $clog2(PHT_DEPTH),
    localparam int PTR_W      = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             predict_en,
    input  logic [31:0]      fetch_pc_n,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_rdata,
    input  logic             fetch_valid,
    input  logic             predict_fail,
    input  logic [GHR_W-1:0] fail_ghr,
    input  logic [PTR_W-1:0] fail_ras_ptr,
    input  logic [PTR_W:0]   fail_ras_cnt,
    input  logic             bht_update,
    input  logic [31:0]      bht_pc,
    input  logic [GHR_W-1:0] bht_ghr,
    input  logic             bht_taken,
    output logic             predict_taken,
    output logic [31:0]      predict_pc,
    output logic [GHR_W-1:0] predict_ghr,
    output logic [PTR_W-1:0] predict_ras_ptr,
    output logic [PTR_W:0]   predict_ras_cnt
);

    logic [31:0] inst;
    logic        is_rvc, is_br, is_jmp, is_call, is_ret;
    logic [31:0] imm;

    assign inst   = fetch_rdata;
    assign is_rvc = (inst[1:0] != 2'b11);

    always_comb begin
        is_br   = 1'b0;
        is_jmp  = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        imm     = '0;
        if (!is_rvc) begin
            case (inst[6:0])
                OPC_BRANCH: begin
                    is_br = 1'b1;
                    imm   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OPC_JAL: begin
                    is_jmp  = 1'b1;
                    is_call = is_link(inst[11:7]);
                    imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OPC_JALR: begin
                    is_call = is_link(inst[11:7]);
                    is_ret  = is_link(inst[19:15]) && (inst[19:15] != inst[11:7]);
                end
                default: ;
            endcase
        end else begin
            case ({inst[15:13], inst[1:0]})
                5'b101_01, 5'b001_01: begin
                    is_jmp  = 1'b1;
                    is_call = (inst[15:13] == 3'b001);
                    imm     = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                               inst[2], inst[11], inst[5:3], 1'b0};
                end
                5'b110_01, 5'b111_01: begin
                    is_br = 1'b1;
                    imm   = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                             inst[4:3], 1'b0};
                end
                5'b100_10: begin
                    // c.jr / c.jalr: rs2 must be zero and rs1 non-zero.
                    if ((inst[6:2] == 5'd0) && (inst[11:7] != 5'd0)) begin
                        is_call = inst[12];
                        is_ret  = !inst[12] && is_link(inst[11:7]);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [31:0]      ras_top;
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;
    logic             fire, spec_upd, ret_hit;
    logic [1:0]       pht_rd_q, pht_rd_d;

    assign fire     = fetch_valid && predict_en;
    assign spec_upd = fire && !predict_fail;
    assign ret_hit  = ENA_RAS && is_ret && (ras_cnt != '0);

    ras_snap_t w_snap;
    assign w_snap.ptr = SNAP_PTR_W'(ras_ptr);
    assign w_snap.cnt = (SNAP_PTR_W+1)'(ras_cnt);

    always_comb begin
        predict_taken   = 1'b0;
        predict_pc      = '0;
        predict_ghr     = '0;
        predict_ras_ptr = '0;
        predict_ras_cnt = '0;
        if (fire) begin
            predict_ghr     = ghr_q;
            predict_ras_ptr = w_snap.ptr[PTR_W-1:0];
            predict_ras_cnt = w_snap.cnt[PTR_W:0];
            if (is_br) begin
                predict_taken = pht_rd_q[1];
                predict_pc    = fetch_pc + imm;
            end else if (is_jmp) begin
                predict_taken = ENA_JUMP;
                predict_pc    = fetch_pc + imm;
            end else if (ret_hit) begin
                predict_taken = 1'b1;
                predict_pc    = ras_top;
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (predict_fail)
            ghr_d = fail_ghr;
        else if (spec_upd && is_br)
            ghr_d = GHR_W'({ghr_q, pht_rd_q[1]});
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (spec_upd && ENA_RAS && is_call),
        .pop         (spec_upd && ret_hit),
        .push_data   (fetch_pc + (is_rvc ? 32'd2 : 32'd4)),
        .restore     (predict_fail),
        .restore_ptr (fail_ras_ptr),
        .restore_cnt (fail_ras_cnt),
        .top         (ras_top),
        .ptr         (ras_ptr),
        .cnt         (ras_cnt)
    );

    logic [1:0]       pht_q [PHT_DEPTH];
    logic [IDX_W-1:0] rd_idx, wr_idx;

    generate
        if (ENA_GSHARE) begin : g_gshare
            assign rd_idx = fetch_pc_n[IDX_W:1] ^ IDX_W'(ghr_q);
            assign wr_idx = bht_pc[IDX_W:1] ^ IDX_W'(bht_ghr);
        end else begin : g_bimodal
            assign rd_idx = fetch_pc_n[IDX_W:1];
            assign wr_idx = bht_pc[IDX_W:1];
        end
    endgenerate

    // Read data is registered off the pre-write array, so a same-index train
    // in the same cycle is seen only on the following read.
    assign pht_rd_d = predict_en ? pht_q[rd_idx] : pht_rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q    <= '0;
            pht_rd_q <= WNT;
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= WNT;
        end else begin
            ghr_q    <= ghr_d;
            pht_rd_q <= pht_rd_d;
            if (bht_update) pht_q[wr_idx] <= ctr_next(pht_q[wr_idx], bht_taken);
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, fetch_pc_n[31:IDX_W+1], fetch_pc_n[0],
                         bht_pc[31:IDX_W+1], bht_pc[0], bht_ghr, w_snap};

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_gshare_ras.sv
// ============================================================================
//  Module      : tb_branch_predict_gshare_ras
//  Description : Directed scoreboard bench for the gshare/RAS fetch predictor.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_gshare_ras;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        predict_en, fetch_valid, predict_fail, bht_update, bht_taken;
    logic [31:0] fetch_pc_n, fetch_pc, fetch_rdata, bht_pc, predict_pc;
    logic [7:0]  fail_ghr, bht_ghr, predict_ghr;
    logic [2:0]  fail_ras_ptr, predict_ras_ptr;
    logic [3:0]  fail_ras_cnt, predict_ras_cnt;
    logic        predict_taken;

    always #5 clk = ~clk;

    branch_predict_gshare_ras dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .predict_en      (predict_en),
        .fetch_pc_n      (fetch_pc_n),
        .fetch_pc        (fetch_pc),
        .fetch_rdata     (fetch_rdata),
        .fetch_valid     (fetch_valid),
        .predict_fail    (predict_fail),
        .fail_ghr        (fail_ghr),
        .fail_ras_ptr    (fail_ras_ptr),
        .fail_ras_cnt    (fail_ras_cnt),
        .bht_update      (bht_update),
        .bht_pc          (bht_pc),
        .bht_ghr         (bht_ghr),
        .bht_taken       (bht_taken),
        .predict_taken   (predict_taken),
        .predict_pc      (predict_pc),
        .predict_ghr     (predict_ghr),
        .predict_ras_ptr (predict_ras_ptr),
        .predict_ras_cnt (predict_ras_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [7:0]  ghr;
        logic [2:0]  ptr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every negedge either consumes one expected prediction or
    // checks that the idle outputs are all zero.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_valid && predict_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pred pc=%h: got tk=%0d tgt=%h, none expected",
                             fetch_pc, predict_taken, predict_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (predict_taken !== e.tk || predict_pc !== e.tgt || predict_ghr !== e.ghr ||
                        predict_ras_ptr !== e.ptr || predict_ras_cnt !== e.cnt) begin
                        n_bad++;
                        $display("FAIL pred@%h: got tk=%0d tgt=%h ghr=%h ptr=%0d cnt=%0d, want tk=%0d tgt=%h ghr=%h ptr=%0d cnt=%0d",
                                 e.pc, predict_taken, predict_pc, predict_ghr, predict_ras_ptr,
                                 predict_ras_cnt, e.tk, e.tgt, e.ghr, e.ptr, e.cnt);
                    end
                end
            end else begin
                n_cmp++;
                if ({predict_taken, predict_pc, predict_ghr, predict_ras_ptr, predict_ras_cnt} !== '0) begin
                    n_bad++;
                    $display("FAIL idle_zero: got tk=%0d tgt=%h ghr=%h ptr=%0d cnt=%0d, want all 0",
                             predict_taken, predict_pc, predict_ghr, predict_ras_ptr, predict_ras_cnt);
                end
            end
        end
    end

    // One cycle presenting the PC on fetch_pc_n for the PHT read, then the
    // fetch itself; the expected response is queued for the monitor.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins, input logic tk,
                         input logic [31:0] tgt, input logic [7:0] g, input logic [2:0] p,
                         input logic [3:0] c, input logic fl);
        exp_t e;
        fetch_valid = 1'b0;
        predict_en  = 1'b1;
        fetch_pc_n  = pc;
        @(posedge clk); #1;
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_rdata  = ins;
        fetch_pc_n   = pc + 32'd4;
        predict_fail = fl;
        e.pc = pc; e.tk = tk; e.tgt = tgt; e.ghr = g; e.ptr = p; e.cnt = c;
        exp_q.push_back(e);
        @(posedge clk); #1;
        fetch_valid  = 1'b0;
        predict_fail = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [7:0] g, input logic t);
        bht_update = 1'b1;
        bht_pc     = pc;
        bht_ghr    = g;
        bht_taken  = t;
        @(posedge clk); #1;
        bht_update = 1'b0;
    endtask

    localparam logic [31:0] BEQ16   = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JAL1_256 = 32'h1000_00EF; // jal x1,+0x100
    localparam logic [31:0] JAL1_0  = 32'h0000_00EF;  // jal x1,+0
    localparam logic [31:0] C_RET   = 32'h0000_8082;  // c.jr x1
    localparam logic [31:0] JALR15  = 32'h0002_80E7;  // jalr x1,0(x5)
    localparam logic [31:0] JALR06  = 32'h0003_0067;  // jalr x0,0(x6)
    localparam logic [31:0] C_J32   = 32'h0000_A005;  // c.j +0x20
    localparam logic [31:0] C_BEQZ8 = 32'h0000_C401;  // c.beqz x8,+8
    localparam logic [31:0] NOP     = 32'h0000_0013;

    initial begin
        reset_n      = 1'b0;
        predict_en   = 1'b0;
        fetch_valid  = 1'b0;
        predict_fail = 1'b0;
        bht_update   = 1'b0;
        bht_taken    = 1'b0;
        fetch_pc_n   = '0;
        fetch_pc     = '0;
        fetch_rdata  = '0;
        bht_pc       = '0;
        bht_ghr      = '0;
        fail_ghr     = '0;
        fail_ras_ptr = '0;
        fail_ras_cnt = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        predict_en = 1'b1;

        // Untrained branch, then trained to strongly taken.
        fetch(32'h100, BEQ16, 1'b0, 32'h110, 8'h00, 3'd0, 4'd0, 1'b0);
        train(32'h100, 8'h00, 1'b1);
        train(32'h100, 8'h00, 1'b1);
        fetch(32'h100, BEQ16, 1'b1, 32'h110, 8'h00, 3'd0, 4'd0, 1'b0);

        // Call then return.
        fetch(32'h200, JAL1_256, 1'b1, 32'h300, 8'h01, 3'd0, 4'd0, 1'b0);
        fetch(32'h300, C_RET,    1'b1, 32'h204, 8'h01, 3'd1, 4'd1, 1'b0);

        // Nine calls overflow the 8-entry stack; nine returns drain it.
        for (int k = 0; k < 9; k++)
            fetch(32'h1000 + 32'(k * 16), JAL1_0, 1'b1, 32'h1000 + 32'(k * 16), 8'h01,
                  3'(k), (k > 8) ? 4'd8 : 4'(k), 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8)
                fetch(32'h2000, C_RET, 1'b1, 32'h1004 + 32'((8 - i) * 16), 8'h01,
                      3'((1 - i) & 7), 4'(8 - i), 1'b0);
            else
                fetch(32'h2000, C_RET, 1'b0, 32'h0, 8'h01, 3'd1, 4'd0, 1'b0);
        end

        // Misprediction restore in the same cycle as a call: no push.
        fail_ghr     = 8'h5A;
        fail_ras_ptr = 3'd3;
        fail_ras_cnt = 4'd3;
        fetch(32'h3000, JAL1_0, 1'b1, 32'h3000, 8'h01, 3'd1, 4'd0, 1'b1);
        fetch(32'h2000, C_RET,  1'b1, 32'h1024, 8'h5A, 3'd3, 4'd3, 1'b0);

        // Call+return in one jalr rewrites the top in place.
        fetch(32'h4000, JALR15, 1'b1, 32'h1014, 8'h5A, 3'd2, 4'd2, 1'b0);
        fetch(32'h2000, C_RET,  1'b1, 32'h4004, 8'h5A, 3'd2, 4'd2, 1'b0);
        fetch(32'h2000, C_RET,  1'b1, 32'h1084, 8'h5A, 3'd1, 4'd1, 1'b0);

        // RVC jump/branch immediates, plain jalr, non-control instruction.
        fetch(32'h500, C_J32,   1'b1, 32'h520, 8'h5A, 3'd0, 4'd0, 1'b0);
        fetch(32'h600, C_BEQZ8, 1'b0, 32'h608, 8'h5A, 3'd0, 4'd0, 1'b0);
        fetch(32'h680, JALR06,  1'b0, 32'h0,   8'hB4, 3'd0, 4'd0, 1'b0);
        fetch(32'h700, NOP,     1'b0, 32'h0,   8'hB4, 3'd0, 4'd0, 1'b0);

        // Mid-operation reset clears GHR, RAS and PHT training.
        fetch(32'h800, JAL1_0,  1'b1, 32'h800, 8'hB4, 3'd0, 4'd0, 1'b0);
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        fetch(32'h2000, C_RET, 1'b0, 32'h0,   8'h00, 3'd0, 4'd0, 1'b0);
        fetch(32'h100,  BEQ16, 1'b0, 32'h110, 8'h00, 3'd0, 4'd0, 1'b0);

        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predict_gshare_ras.md
Name: branch_predict_gshare_ras

Overview:
Next-generation fetch-stage predictor for the riscv core. It pre-decodes the fetched RV32/RVC instruction and predicts the next PC for conditional branches, direct jumps and returns. Conditional branches use a gshare pattern history table (PHT) of 2-bit counters indexed by PC XOR a speculative global history register (GHR). Returns use a parametrised return-address stack (RAS) with checkpoint/restore on misprediction. The block sits beside the IF stage and is updated from EX.

Parameters:
PHT_DEPTH, 1024, number of 2-bit counters; power of 2; IDX_W = log2(PHT_DEPTH).
GHR_W, 8, global history bits; 0 < GHR_W <= IDX_W.
ENA_GSHARE, 1, 1 = XOR GHR into the index; 0 = bimodal index, GHR still tracked.
RAS_DEPTH, 8, RAS entries; power of 2, >= 2; PTR_W = log2(RAS_DEPTH).
ENA_RAS, 1, 0 = returns are treated as plain jalr (not predicted); the stack is never written.
ENA_JUMP, 1, 1 = jal/c.j/c.jal are predicted taken.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
predict_en  in  1  enable lookup and speculative state update
fetch_pc_n  in  32  next fetch PC, used for the registered PHT read
fetch_pc  in  32  PC of fetch_rdata
fetch_rdata  in  32  fetched instruction (RVC in [15:0])
fetch_valid  in  1  fetch_rdata valid
predict_fail  in  1  EX misprediction; restore the speculative state
fail_ghr  in  GHR_W  corrected GHR (includes the resolved outcome)
fail_ras_ptr  in  PTR_W  RAS top pointer to restore
fail_ras_cnt  in  PTR_W+1  RAS occupancy to restore
bht_update  in  1  train the PHT
bht_pc  in  32  PC of the resolved branch
bht_ghr  in  GHR_W  GHR snapshot taken when that branch was predicted
bht_taken  in  1  resolved direction
predict_taken  out  1  redirect fetch
predict_pc  out  32  redirect target
predict_ghr  out  GHR_W  GHR snapshot for this instruction; carried down the pipeline
predict_ras_ptr  out  PTR_W  RAS pointer before this instruction
predict_ras_cnt  out  PTR_W+1  RAS occupancy before this instruction

Behaviour:
- Reset (async): GHR=0; RAS ptr=0, cnt=0, entries=0; all PHT counters=2'b01 (weakly not-taken); registered read data=2'b01.
- Outputs are combinational from the current state and fetch_*. They are all 0 whenever fetch_valid=0 or predict_en=0, and therefore 0 out of reset.
- Decode: RV branch/jal/jalr opcodes; RVC c.beqz/c.bnez/c.j/c.jal/c.jr/c.jalr; standard RVC immediates.
- call = jal/jalr with rd∈{x1,x5}, or c.jal/c.jalr.
- return = jalr with rs1∈{x1,x5} and rs1≠rd, or c.jr with rs1∈{x1,x5}.
- PHT read: index = fetch_pc_n[IDX_W:1] XOR ({IDX_W-GHR_W zeros, GHR} when ENA_GSHARE). The index is registered when predict_en=1, so the counter is available with fetch_pc one cycle later.
- Branch: predict_taken = counter[1]; predict_pc = fetch_pc + imm (32-bit wrap).
- Direct jump: predict_taken = ENA_JUMP; predict_pc = fetch_pc + imm.
- Return with ENA_RAS=1 and cnt≠0: predict_taken = 1; predict_pc = stack[ptr-1].
- Return with cnt=0, non-return jalr, or ENA_RAS=0: predict_taken = 0.
- Speculative update fires when fetch_valid & predict_en & ~predict_fail.
- Branch update: GHR <= {GHR[GHR_W-2:0], predicted dir}.
- Call update (push): stack[ptr] <= fetch_pc + (RVC ? 2 : 4); ptr++ (modulo RAS_DEPTH); cnt = min(cnt+1, RAS_DEPTH). Overflow overwrites the oldest entry.
- Return update (pop): ptr--; cnt--. Never popped when cnt=0.
- Call and return in the same instruction: pop then push, i.e. stack[ptr-1] <= return address; ptr and cnt unchanged.
- predict_fail: GHR <= fail_ghr; ptr <= fail_ras_ptr; cnt <= fail_ras_cnt. This has priority over any same-cycle speculative update. Stack contents are not restored.
- Training (bht_update): index = bht_pc[IDX_W:1] XOR bht_ghr (when ENA_GSHARE). The counter saturates at 00/11.
- Training is independent of predict_fail.
- Read and train to the same index in the same cycle: the read returns the old value.
- Snapshot outputs predict_ghr, predict_ras_ptr and predict_ras_cnt show the pre-update state.
- Mid-operation reset clears all state immediately.

Decomposition:
- riscv_pkg: opcode constants (shared with the existing predictor), the 2-bit counter encodings SNT/WNT/WT/ST, and typedef ras_snap_t {ptr, cnt}.
- Sub-module ras_stack (params RAS_DEPTH): push, pop, push_data, restore, restore_ptr, restore_cnt, top, ptr, cnt.
- The PHT stays inline.

Test Plan:
- Reset, then fetch beq at pc 0x100 with imm +16 -> predict_taken=0, predict_pc=0x110, GHR stays 0x00 then shifts to 0x00.
- Train bht_pc=0x100, bht_ghr=0 taken twice, then refetch with GHR=0 -> counter 11, predict_taken=1, predict_pc=0x110; GHR becomes 0x01.
- jal x1 at 0x200 then c.jr x1 -> push 0x204; return predicts taken with predict_pc=0x204; cnt returns 1->0.
- Nine calls with RAS_DEPTH=8, then nine returns -> first eight returns predicted (last pushed first), cnt saturates at 8, ninth return predict_taken=0.
- predict_fail with fail_ghr=0x5A, fail_ras_ptr=3, fail_ras_cnt=3 in the same cycle as a fetched call -> GHR=0x5A, ptr=3, cnt=3; no push occurs.
- jalr x1,x5 (call+return) with cnt=2 -> predict_pc = old top, top replaced by pc+4, cnt stays 2.
